vigenere_decipher: RTL and testbench
====================================

// Module: vigenere_decipher
// PURPOSE
//  Inverse of the Vigenere encoder: recovers lowercase plaintext from ciphertext, one char per accepted strobe.
//  Cycles through NUM_KEYS key bytes; char n (counted from reset/restart) uses key slot n mod key_len.
//  Sits between the keyboard/char source and the display/LED path on the receive side.
// PARAMETERS
//  NUM_KEYS  4  number of key byte slots in key_arr (>=2); IDX_W = $clog2(NUM_KEYS)
// PORTS
//  keyboard_clk  in   1             sole clock, rising edge
//  reset         in   1             asynchronous, active-high
//  key_arr       in   8*NUM_KEYS    key bytes; slot i = key_arr[8*i+7:8*i]; slot 0 used first
//  key_len       in   IDX_W+1       active key length; 0 or >NUM_KEYS -> NUM_KEYS
//  restart       in   1             synchronous: next key index back to slot 0
//  in_valid      in   1             char_in valid this cycle (1-cycle strobe, no backpressure)
//  char_in       in   8             ciphertext ASCII
//  out_valid     out  1             char_out updated this cycle (1-cycle pulse)
//  char_out      out  8             plaintext ASCII
//  IDX_out       out  IDX_W         key slot to be applied to the next accepted char
// BEHAVIOUR
//  Reset (async, held): char_out=8'd32, out_valid=0, IDX=0; nothing accepted while reset is high.
//  Key shift k(slot): 'a'..'z' -> byte-97; 'A'..'Z' -> byte-65; any other byte -> 0 (pass-through).
//  Decode, 9-bit arithmetic, no underflow: c in 97..122: p=c-k; if p<97 then p+=26. Else p=32.
//  Latency 1: in_valid at edge N -> char_out/out_valid valid after edge N; out_valid low otherwise.
//  char_out holds its last value while out_valid=0.
//  Index FSM: IDX in 0..L-1, L = effective key_len.
//   On accept: use slot IDX; IDX <= (IDX>=L-1) ? 0 : IDX+1.
//   Non-letter chars still consume a slot (matches the encoder, which advances per char).
//   L=1: IDX stays 0, plain Caesar decode.
//  restart without in_valid: IDX <= 0, no output.
//  restart with in_valid: char decoded with slot 0; IDX <= (L==1) ? 0 : 1.
//  key_arr change: applies from the next accepted char; IDX unchanged.
//  key_len change: if IDX >= new L, the next accepted char uses slot 0.
//  Back-to-back in_valid every cycle: each char processed, no drops, no stalls.
//  Reset mid-stream: in-flight out_valid cleared immediately; IDX=0 on release.
//  No combinational path from inputs to outputs; all outputs registered.
// TESTING
//  1 key_arr="omel" (slot0='l'), key_len=4; send "lfor" -> "abcd", IDX_out 1,2,3,0.
//  2 Wrap: key slot0='b', key_len=1; char 'a' -> 'z'; 'b' -> 'a'; uppercase key 'B' gives the same results.
//  3 Non-letter: key "omel" len 4; send "l!or" -> 'a',32,'c','d'; '!' consumes slot 1.
//  4 key_len=2 on "omel": send "lfnh" -> "abcd"; key_len=0 then behaves as 4.
//  5 Stream "lf", pulse restart with 'l' -> 'a'; then IDX_out=1.
//    Async reset mid-stream -> out_valid=0, char_out=32, IDX_out=0 immediately.
//  6 Random 1000 chars, random key/len: an encoder model indexed per char, then this block,
//    returns the original text; non-letters return 32; in_valid asserted every cycle.

Source files
------------

// File: rtl/vigenere_decipher_if.sv
// Character stream bundle for the Vigenere decipher: strobed ciphertext in,
// registered plaintext out, plus the key slot that the next accepted character will use.
interface vigenere_decipher_if #(
    parameter int NUM_KEYS = 4
);
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic             in_valid;
    logic [7:0]       char_in;
    logic             restart;
    logic             out_valid;
    logic [7:0]       char_out;
    logic [IDX_W-1:0] IDX_out;

    modport master (
        output in_valid, char_in, restart,
        input  out_valid, char_out, IDX_out
    );

    modport slave (
        input  in_valid, char_in, restart,
        output out_valid, char_out, IDX_out
    );
endinterface

// File: rtl/vigenere_decipher.sv
// Vigenere decipher: one lowercase ciphertext char per strobe, key slot rotating
// over the active key length; non-letters consume a slot and come out as a space.
module vigenere_decipher #(
    parameter int NUM_KEYS = 4
) (
    input  logic                            keyboard_clk,
    input  logic                            reset,
    input  logic [8*NUM_KEYS-1:0]           key_arr,
    input  logic [$clog2(NUM_KEYS):0]       key_len,
    vigenere_decipher_if.slave              bus
);
    localparam int IDX_W = $clog2(NUM_KEYS);
    localparam int LEN_W = IDX_W + 1;
    localparam logic [LEN_W-1:0] NUM_KEYS_L = LEN_W'(NUM_KEYS);
    localparam logic [7:0] CH_SPACE = 8'd32;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       char_out_q, char_out_d;

    logic [7:0]       keys [NUM_KEYS];
    logic [LEN_W-1:0] len_eff;
    logic [IDX_W-1:0] slot;
    logic [LEN_W-1:0] slot_ext;
    logic [IDX_W-1:0] idx_next;
    logic [7:0]       key_byte;
    logic [4:0]       shift;
    logic [7:0]       diff;
    logic [7:0]       plain;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_keys
        assign keys[i] = key_arr[8*i +: 8];
    end

    always_comb begin
        len_eff = key_len;
        if (key_len == '0 || key_len > NUM_KEYS_L) begin
            len_eff = NUM_KEYS_L;
        end
    end

    // A shrunk key_len can leave idx_q past the new end; that char falls back to slot 0.
    always_comb begin
        slot = idx_q;
        if (bus.restart || {1'b0, idx_q} >= len_eff) begin
            slot = '0;
        end
    end

    assign slot_ext = {1'b0, slot};

    always_comb begin
        idx_next = IDX_W'(slot_ext + LEN_W'(1));
        if (slot_ext >= len_eff - LEN_W'(1)) begin
            idx_next = '0;
        end
    end

    assign key_byte = keys[slot];

    always_comb begin
        shift = 5'd0;
        if (key_byte >= 8'd97 && key_byte <= 8'd122) begin
            shift = 5'(key_byte - 8'd97);
        end else if (key_byte >= 8'd65 && key_byte <= 8'd90) begin
            shift = 5'(key_byte - 8'd65);
        end
    end

    // char_in >= 97 and shift <= 25, so the subtraction cannot underflow.
    always_comb begin
        diff  = bus.char_in - {3'b000, shift};
        plain = CH_SPACE;
        if (bus.char_in >= 8'd97 && bus.char_in <= 8'd122) begin
            plain = (diff < 8'd97) ? diff + 8'd26 : diff;
        end
    end

    always_comb begin
        out_valid_d = bus.in_valid;
        char_out_d  = char_out_q;
        idx_d       = idx_q;
        if (bus.in_valid) begin
            char_out_d = plain;
            idx_d      = idx_next;
        end else if (bus.restart) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge keyboard_clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            char_out_q  <= CH_SPACE;
        end else begin
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            char_out_q  <= char_out_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.char_out  = char_out_q;
    assign bus.IDX_out   = idx_q;
endmodule

// File: tb/tb_vigenere_decipher.sv
// Bench for vigenere_decipher: directed key/wrap/restart/reset cases plus a
// random encode-then-decode round trip against a modular-arithmetic reference.
module tb_vigenere_decipher;
    localparam int NUM_KEYS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] key_arr = '0;
    logic [2:0]  key_len = '0;

    vigenere_decipher_if #(.NUM_KEYS(NUM_KEYS)) bus ();

    vigenere_decipher #(.NUM_KEYS(NUM_KEYS)) dut (
        .keyboard_clk (clk),
        .reset        (rst),
        .key_arr      (key_arr),
        .key_len      (key_len),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_idx    = 0;
    logic [7:0] m_char = 8'd32;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_len(input logic [2:0] kl);
        return (kl == 0 || kl > NUM_KEYS) ? NUM_KEYS : int'(kl);
    endfunction

    function automatic int key_shift(input logic [7:0] b);
        if (b >= "a" && b <= "z") return int'(b) - 97;
        if (b >= "A" && b <= "Z") return int'(b) - 65;
        return 0;
    endfunction

    function automatic logic [7:0] decode_ref(input logic [7:0] c, input int k);
        if (c >= "a" && c <= "z") return 8'(97 + ((int'(c) - 97 - k + 26) % 26));
        return 8'd32;
    endfunction

    function automatic logic [7:0] encode_ref(input logic [7:0] p, input int k);
        if (p >= "a" && p <= "z") return 8'(97 + ((int'(p) - 97 + k) % 26));
        return p;
    endfunction

    // Called just after a falling edge; returns at the next falling edge with outputs checked.
    task automatic drive(input logic v, input logic [7:0] c, input logic r);
        int L, s;
        logic [7:0] kb;
        bus.in_valid = v;
        bus.char_in  = c;
        bus.restart  = r;
        L = eff_len(key_len);
        if (v) begin
            s = (r || m_idx >= L) ? 0 : m_idx;
            kb = key_arr[8*s +: 8];
            m_char = decode_ref(c, key_shift(kb));
            m_idx  = (s + 1) % L;
        end else if (r) begin
            m_idx = 0;
        end
        @(negedge clk);
        check("out_valid", 32'(bus.out_valid), 32'(v));
        check("char_out", 32'(bus.char_out), 32'(m_char));
        check("idx_out", 32'(bus.IDX_out), 32'(m_idx));
        bus.in_valid = 1'b0;
        bus.restart  = 1'b0;
    endtask

    task automatic send_str(input string s, input string want);
        for (int i = 0; i < s.len(); i++) begin
            drive(1'b1, s[i], 1'b0);
            check("directed", 32'(bus.char_out), 32'(want[i]));
        end
    endtask

    initial begin
        logic [7:0] p, cph, kb;
        int L, enc_n, sel;

        bus.in_valid = 1'b0;
        bus.char_in  = 8'd0;
        bus.restart  = 1'b0;

        // reset state, and nothing accepted while reset is held
        @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_char", 32'(bus.char_out), 32'd32);
        check("rst_idx", 32'(bus.IDX_out), 32'd0);
        bus.in_valid = 1'b1;
        bus.char_in  = "q";
        @(negedge clk);
        check("rst_hold_valid", 32'(bus.out_valid), 32'd0);
        check("rst_hold_char", 32'(bus.char_out), 32'd32);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // basic 4-key decode
        key_arr = "omel";
        key_len = 3'd4;
        send_str("lfor", "abcd");

        // wrap around with a single key, lowercase then uppercase
        key_arr = 32'h0000_0062;
        key_len = 3'd1;
        drive(1'b0, 8'd0, 1'b1);
        send_str("ab", "za");
        key_arr = 32'h0000_0042;
        send_str("ab", "za");

        // non-letter consumes a slot
        key_arr = "omel";
        key_len = 3'd4;
        drive(1'b0, 8'd0, 1'b1);
        send_str("l!or", "a cd");

        // shorter key length, then zero meaning full length
        key_len = 3'd2;
        drive(1'b0, 8'd0, 1'b1);
        send_str("lfnh", "abcd");
        key_len = 3'd0;
        drive(1'b0, 8'd0, 1'b1);
        send_str("lfor", "abcd");

        // restart together with a char
        key_len = 3'd4;
        send_str("lf", "ab");
        drive(1'b1, "l", 1'b1);
        check("restart_char", 32'(bus.char_out), 32'("a"));
        check("restart_idx", 32'(bus.IDX_out), 32'd1);

        // async reset mid-stream
        bus.in_valid = 1'b1;
        bus.char_in  = "f";
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_char", 32'(bus.char_out), 32'd32);
        check("mid_rst_idx", 32'(bus.IDX_out), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_idx  = 0;
        m_char = 8'd32;
        @(negedge clk);

        // random round trip, back-to-back strobes
        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                sel = $urandom_range(0, 9);
                if (sel < 5)      key_arr[8*k +: 8] = 8'($urandom_range(97, 122));
                else if (sel < 9) key_arr[8*k +: 8] = 8'($urandom_range(65, 90));
                else              key_arr[8*k +: 8] = 8'($urandom_range(48, 57));
            end
            key_len = 3'($urandom_range(0, 7));
            L = eff_len(key_len);
            enc_n = 0;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 9) == 0) p = 8'($urandom_range(32, 64));
                else                           p = 8'($urandom_range(97, 122));
                kb  = key_arr[8*(enc_n % L) +: 8];
                cph = encode_ref(p, key_shift(kb));
                enc_n++;
                drive(1'b1, cph, i == 0);
                check("roundtrip", 32'(bus.char_out), (p >= "a" && p <= "z") ? 32'(p) : 32'd32);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
